link_act_bank: RTL
==================

Name: link_act_bank

Overview:
- Parametrised N-channel status-LED driver; successor to the single-channel link_act instances generated per LED in board top-levels.
- Adds shared prescaler, per-channel activity stretch, latched error flash and a global LOCATE mode.
- Sits in the top-level between link/activity/error sources (PCIe, Aurora, router) and PMOD/board LED pins, all in the CLK domain.

Parameters:
- NUM_CH, 8, number of LED channels (1..32)
- PRESCALE, 250000, CLK cycles per tick (1 ms at 250 MHz); legal range >= 1
- ACT_HOLD, 40, ticks an activity indication is stretched
- BLINK_HALF, 60, ticks per half-period of the activity blink
- ERR_HOLD, 500, ticks an error indication is held after the last ERR pulse
- ERR_HALF, 15, ticks per half-period of the error/locate flash

Ports:
- CLK  input  1  system clock
- RST_N  input  1  synchronous active-low reset
- LINK  input  NUM_CH  per-channel link up, level
- ACT  input  NUM_CH  per-channel activity, sampled every cycle
- ERR  input  NUM_CH  per-channel error, sampled every cycle
- LOCATE  input  1  level; flashes all LEDs for board identification
- LED  output  NUM_CH  registered LED drive, 1 = lit
- TICK  output  1  registered prescaler tick pulse, for debug and test

Behaviour:
- Reset (RST_N low at a CLK edge): prescaler, all counters, both phase bits, TICK and LED are 0. Reset asserted mid-operation clears all state on that edge; no partial stretch survives.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - TICK is 1 for exactly one cycle, on the cycle the count equals PRESCALE-1.
  - PRESCALE=1 gives TICK=1 every cycle after reset.
- Blink phase: blink_cnt counts ticks 0..BLINK_HALF-1; at wrap blink_ph toggles. Shared by all channels, so channels blink in lockstep.
- Flash phase: identical to blink phase but using ERR_HALF; produces flash_ph.
- Per-channel activity counter act_cnt, width clog2(ACT_HOLD+1):
  - ACT[i]=1 loads ACT_HOLD.
  - Otherwise, on TICK with act_cnt != 0, decrements by 1.
  - Load wins over decrement when both occur in the same cycle.
  - act_busy = (act_cnt != 0).
- Per-channel error counter err_cnt: same rules as act_cnt, using ERR[i] and ERR_HOLD. err_busy = (err_cnt != 0).
- LED[i] priority, first match wins, registered (one-cycle latency from state):
  1. LOCATE=1 -> flash_ph
  2. err_busy -> flash_ph
  3. LINK[i]=0 -> 0
  4. act_busy -> blink_ph
  5. else -> 1
- LINK has no stretch. A LINK drop while act_busy forces LED=0 on the next cycle; the activity count keeps running.
- Counters saturate at 0 and never wrap below 0. Counter widths are derived from the parameters; there is no overflow.
- All state updates occur only on CLK edges; there is no combinational path from inputs to LED.

Decomposition:
- Shared package/header:
  - Default timing constants (DEF_PRESCALE, DEF_ACT_HOLD, DEF_BLINK_HALF, DEF_ERR_HOLD, DEF_ERR_HALF).
  - clog2 function used for counter widths.
- Sub-module link_act_chan:
  - One instance per channel via generate loop.
  - Holds act_cnt, err_cnt and the LED priority mux.
  - Inputs: TICK, blink_ph, flash_ph, LOCATE, LINK/ACT/ERR bit.
- Top of link_act_bank holds the prescaler and both phase generators.

Test Plan:
(Bench parameters: NUM_CH=4, PRESCALE=4, ACT_HOLD=3, BLINK_HALF=2, ERR_HOLD=5, ERR_HALF=1.)
- Reset and prescaler: hold RST_N=0 for 3 cycles with all inputs 1 -> LED=0000 and TICK=0 throughout. Release -> first TICK on the 4th cycle after release, then every 4 cycles; blink_ph toggles every 8 cycles.
- Link/activity: LINK=0001, single-cycle ACT=0001 -> LED[0] follows blink_ph for exactly 3 ticks (12 cycles ±3 depending on prescaler phase), then LED[0]=1 steady; LED[3:1]=0.
- Retrigger and simultaneity: ACT[0] pulsed on the same cycle as TICK while act_cnt=1 -> act_cnt reloads to 3 (not 0); LED[0] keeps blinking for 3 further ticks.
- Error priority: LINK=1111, ACT=1111 held, 1-cycle ERR=0100 -> LED[2] toggles every tick for 5 ticks, then returns to blink_ph; the other channels stay on blink_ph.
- LOCATE and LINK drop: LOCATE=1 with LINK=0000 -> all four LEDs equal flash_ph (toggle every 4 cycles). LOCATE=0 -> LED=0000 on the next cycle.
- Mid-operation reset: ERR=1111 pulse, then RST_N=0 for 1 cycle two ticks later -> LED=0000 next cycle; after release with LINK=1111 and no ERR/ACT -> LED=1111 one cycle later, no residual flash.

Source files
------------

// File: rtl/link_act_bank_pkg.sv
// Shared constants and helpers for the status-LED bank.
package link_act_bank_pkg;

  localparam int DEF_PRESCALE   = 250000;
  localparam int DEF_ACT_HOLD   = 40;
  localparam int DEF_BLINK_HALF = 60;
  localparam int DEF_ERR_HOLD   = 500;
  localparam int DEF_ERR_HALF   = 15;

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/link_act_bank_chan.sv
// One LED channel: activity/error stretch counters and LED priority mux.
module link_act_chan
  import link_act_bank_pkg::*;
#(
  parameter int ACT_HOLD = DEF_ACT_HOLD,
  parameter int ERR_HOLD = DEF_ERR_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic blink_ph,
  input  logic flash_ph,
  input  logic locate,
  input  logic link,
  input  logic act,
  input  logic err,
  output logic led
);

  localparam int AW = clog2(ACT_HOLD + 1);
  localparam int EW = clog2(ERR_HOLD + 1);

  logic [AW-1:0] act_cnt;
  logic [EW-1:0] err_cnt;
  logic          act_busy;
  logic          err_busy;
  logic          led_nxt;

  assign act_busy = (act_cnt != '0);
  assign err_busy = (err_cnt != '0);

  always_comb begin
    led_nxt = 1'b1;
    unique case (1'b1)
      locate:                        led_nxt = flash_ph;
      !locate && err_busy:           led_nxt = flash_ph;
      !locate && !err_busy && !link: led_nxt = 1'b0;
      !locate && !err_busy && link
        && act_busy:                 led_nxt = blink_ph;
      default:                       led_nxt = 1'b1;
    endcase
  end

  // A fresh pulse reloads the hold even on a tick cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_cnt <= '0;
      err_cnt <= '0;
      led     <= 1'b0;
    end else begin
      if (act)
        act_cnt <= AW'(ACT_HOLD);
      else if (tick && act_busy)
        act_cnt <= act_cnt - AW'(1);
      if (err)
        err_cnt <= EW'(ERR_HOLD);
      else if (tick && err_busy)
        err_cnt <= err_cnt - EW'(1);
      led <= led_nxt;
    end
  end

endmodule

// File: rtl/link_act_bank.sv
// N-channel status-LED driver with shared prescaler and blink/flash phases.
module link_act_bank
  import link_act_bank_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int ACT_HOLD   = DEF_ACT_HOLD,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int ERR_HOLD   = DEF_ERR_HOLD,
  parameter int ERR_HALF   = DEF_ERR_HALF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] LINK,
  input  logic [NUM_CH-1:0] ACT,
  input  logic [NUM_CH-1:0] ERR,
  input  logic              LOCATE,
  output logic [NUM_CH-1:0] LED,
  output logic              TICK
);

  localparam int PW = clog2(PRESCALE);
  localparam int BW = clog2(BLINK_HALF);
  localparam int FW = clog2(ERR_HALF);

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_nxt;
  logic [BW-1:0] blink_cnt;
  logic [FW-1:0] flash_cnt;
  logic          blink_ph;
  logic          flash_ph;

  assign pre_nxt = (pre_cnt == PW'(PRESCALE - 1)) ? '0
                                                  : pre_cnt + PW'(1);

  // TICK is registered so it lines up with the count reaching its top.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      TICK    <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      TICK    <= (pre_nxt == PW'(PRESCALE - 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      flash_cnt <= '0;
      flash_ph  <= 1'b0;
    end else if (TICK) begin
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (flash_cnt == FW'(ERR_HALF - 1)) begin
        flash_cnt <= '0;
        flash_ph  <= ~flash_ph;
      end else begin
        flash_cnt <= flash_cnt + FW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    link_act_chan #(
      .ACT_HOLD (ACT_HOLD),
      .ERR_HOLD (ERR_HOLD)
    ) u_chan (
      .clk      (CLK),
      .rst_n    (RST_N),
      .tick     (TICK),
      .blink_ph (blink_ph),
      .flash_ph (flash_ph),
      .locate   (LOCATE),
      .link     (LINK[i]),
      .act      (ACT[i]),
      .err      (ERR[i]),
      .led      (LED[i])
    );
  end

endmodule
